// File: rtl/booth_radix4_mult_if.sv
// Operand/result handshake bundle for booth_radix4_mult.
interface booth_radix4_mult_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  // Arithmetic unit side
  modport slave (
    input  in_valid, is_signed, multiplicand, multiplier, out_ready,
    output in_ready, busy, out_valid, product
  );

  // Requester side
  modport master (
    output in_valid, is_signed, multiplicand, multiplier, out_ready,
    input  in_ready, busy, out_valid, product
  );
endinterface

// File: rtl/booth_radix4_mult.sv
// Multi-cycle radix-4 (modified) Booth multiplier, signed or unsigned per
// operation, with valid/ready handshakes on operand and result sides.
module booth_radix4_mult #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_radix4_mult_if.slave    bus
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int QW   = WIDTH + 2;       // extended operand width
  localparam int AW   = WIDTH + 4;       // accumulator width
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_a;
  logic [QW-1:0]       r_q;
  logic                r_qm1;
  logic [QW-1:0]       r_m;
  logic [CW-1:0]       r_cnt;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_out_valid;
  logic [2*WIDTH-1:0]  r_product;

  logic [2:0]          w_trip;
  logic [AW-1:0]       w_mx;
  logic [AW-1:0]       w_m2;
  logic [AW-1:0]       w_addend;
  logic                w_cin;
  logic [AW-1:0]       w_sum;
  logic [AW-1:0]       w_a_nxt;
  logic [QW-1:0]       w_q_nxt;
  logic [2*WIDTH-1:0]  w_prod;
  logic [QW-1:0]       w_m_ext;
  logic [QW-1:0]       w_q_ext;

  // Operand extension at accept: sign fill only in signed mode
  always_comb begin
    w_m_ext = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    w_q_ext = {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
  end

  // Booth recoding, partial-product add and 2-bit arithmetic shift
  always_comb begin
    w_trip   = {r_q[1:0], r_qm1};
    w_mx     = {{2{r_m[QW-1]}}, r_m};
    w_m2     = {w_mx[AW-2:0], 1'b0};
    w_addend = '0;
    w_cin    = 1'b0;
    case (w_trip)
      3'b001, 3'b010: w_addend = w_mx;
      3'b011:         w_addend = w_m2;
      3'b100: begin
        w_addend = ~w_m2;
        w_cin    = 1'b1;
      end
      3'b101, 3'b110: begin
        w_addend = ~w_mx;
        w_cin    = 1'b1;
      end
      default:        w_addend = '0;
    endcase
    w_sum   = r_a + w_addend + {{(AW-1){1'b0}}, w_cin};
    w_a_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    w_q_nxt = {w_sum[1:0], r_q[QW-1:2]};
    // Low 2*WIDTH bits of the shifted {A,Q}, taken straight from the sum
    w_prod  = {w_sum[WIDTH-1:0], r_q[QW-1:2]};
  end

  // Control FSM with registered handshake outputs and datapath state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_qm1       <= 1'b0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_product   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_m        <= w_m_ext;
            r_q        <= w_q_ext;
            r_a        <= '0;
            r_qm1      <= 1'b0;
            r_cnt      <= CW'(ITER - 1);
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= r_q[1];
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_product   <= w_prod;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_product;

endmodule

// File: doc/booth_radix4_mult.md
# booth_radix4_mult

Parametrised radix-4 (modified) Booth multiplier: the next generation of the team's serial radix-2 Booth datapath. It adds a configurable operand width, a per-operation signed/unsigned mode, and two Booth digits per step. It also adds valid/ready handshakes on both operand and result sides, including result backpressure. It sits as a multi-cycle arithmetic unit behind a requester that presents both operands in parallel and collects a full double-width product.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 4.
- ITER (localparam), WIDTH/2+1, number of radix-4 iterations per operation.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- is_signed  input  1  1: operands are two's-complement; 0: operands are unsigned; sampled at accept.
- multiplicand  input  WIDTH  operand M; sampled at accept.
- multiplier  input  WIDTH  operand Q; sampled at accept.
- busy  output  1  high in RUN or DONE.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer takes product.
- product  output  2*WIDTH  M×Q, exact, in the selected signedness.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1, out_valid=0. Accept occurs when in_valid&in_ready is sampled at a rising edge.
- Accept edge:
  - M is extended to WIDTH+2 bits: sign-extended if is_signed, else zero-extended.
  - Q is extended to WIDTH+2 bits the same way.
  - Accumulator A (WIDTH+4 bits) and Q(-1) are cleared.
  - Iteration counter is set to ITER-1.
  - State → RUN.
- RUN, one step per cycle:
  - Recode triplet {Q[1],Q[0],Q(-1)} to a digit in {0,±1,±2}.
  - A ← A + digit·M. M and 2M are sign-extended to WIDTH+4. Negation uses invert plus carry-in.
  - Arithmetic shift right by 2 of {A,Q,Q(-1)}.
  - Counter decrements. On the step with counter=0, state → DONE.
- Unsigned operands need the extra top digit; in signed mode that digit is always 0. The iteration count is therefore ITER in both modes (no early termination).
- DONE:
  - product = low 2*WIDTH bits of {A,Q} (final shifted alignment). The full result always fits in 2*WIDTH bits in either mode.
  - out_valid=1.
  - On an edge with out_ready=1: state → IDLE, out_valid → 0.
- Operand inputs and is_signed are ignored outside the accept edge. in_valid in RUN/DONE is not accepted and not queued.
- product holds its value from entry to DONE until the next accept. It is don't-care-free: it is never X after reset.

## Timing
- Reset values (asynchronous, immediate on rst=1):
  - state=IDLE, in_ready=1, busy=0, out_valid=0, product=0.
  - A, Q, M, counter are cleared.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced for it. The block is in IDLE on the first edge after rst deasserts.
- Latency:
  - Accept at edge k; steps at edges k+1…k+ITER; out_valid=1 after edge k+ITER.
  - WIDTH=8: 5 cycles. WIDTH=16: 9 cycles.
- Throughput without backpressure: one operation per ITER+2 cycles. The minimum is 1 DONE cycle plus 1 IDLE cycle before the next accept.
- Backpressure: out_valid and product are held stable for any number of cycles while out_ready=0.
- out_ready asserted before out_valid has no effect. in_ready falls on the edge after accept.
- Combinational paths: none from inputs to outputs. in_ready, busy, out_valid and product are register-decoded.

## Test plan
- WIDTH=8, signed, M=-7 (0xF9), Q=3 -> out_valid exactly 5 cycles after accept, product=0xFFEB (-21).
- WIDTH=8, signed, M=-128, Q=-128 -> product=0x4000. M=-128, Q=127 -> product=0xC080 (-16256).
- WIDTH=8, unsigned, M=255, Q=255 -> product=0xFE01. Same operands signed (-1×-1) -> product=0x0001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> product and out_valid are stable, in_ready=0 throughout. in_valid pulsed with new operands during RUN/DONE -> ignored; the result is the original product.
- Reset: assert rst for 1 cycle at step 2 of RUN -> out_valid, product, busy are 0 immediately. in_ready=1 after release. The next operation, 6×7 signed, yields 0x002A.
- WIDTH=16: 10k random operands with random is_signed, random in_valid/out_ready gaps, back-to-back accepts -> every product matches a scoreboard model. Latency is 9 cycles. No lost or duplicated results.
